// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one async SRAM between fetch and data ports; setup/strobe/recovery sequencing.
// Define ARB_RR_EN for round-robin arbitration on simultaneous requests (default: data wins).
module ram_arbiter #(
    parameter int         ACCESS_CYCLES = 2,
    parameter logic [1:0] ADDR_HI       = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_valid,
    output logic        d_stall,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dout,
    output logic        sram_dout_oe,
    input  logic [15:0] sram_din,
    output logic        sram_en_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_DONE} state_t;

    localparam logic [2:0] LP_CNT_INIT = 3'(ACCESS_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cnt;
    logic        r_owner_d;
    logic        r_we;
    logic [17:0] r_sram_addr;
    logic [15:0] r_sram_dout;
    logic        r_sram_dout_oe;
    logic        r_sram_en_n;
    logic        r_sram_oe_n;
    logic        r_sram_we_n;
    logic [15:0] r_if_rdata;
    logic [15:0] r_d_rdata;
    logic        r_if_valid;
    logic        r_d_valid;

    logic        w_any_req;
    logic        w_grant_d;
    logic        w_we_sel;
    logic        w_en_n_nxt;
    logic        w_oe_n_nxt;
    logic        w_we_n_nxt;
    logic        w_dout_oe_nxt;
    logic        w_done_nxt;

    assign w_any_req = if_req | d_req;

`ifdef ARB_RR_EN
    logic r_ptr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr_d <= 1'b1;
        end else if (r_state == S_DONE) begin
            r_ptr_d <= ~r_owner_d;
        end
    end

    assign w_grant_d = d_req & (~if_req | r_ptr_d);
`else
    assign w_grant_d = d_req;
`endif

    // In IDLE the write flag is not latched yet, so take it from the winning request.
    assign w_we_sel = (r_state == S_IDLE) ? (w_grant_d & d_we) : r_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_next = S_SETUP;
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: if (r_cnt == 3'd0) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Controls are registered, so decode them from the state being entered.
    always_comb begin
        w_en_n_nxt    = (w_next == S_IDLE);
        w_oe_n_nxt    = !((w_next == S_STROBE) && !w_we_sel);
        w_we_n_nxt    = !((w_next == S_STROBE) && w_we_sel);
        w_dout_oe_nxt = (w_next != S_IDLE) && w_we_sel;
        w_done_nxt    = (w_next == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt          <= 3'd0;
            r_owner_d      <= 1'b0;
            r_we           <= 1'b0;
            r_sram_addr    <= 18'd0;
            r_sram_dout    <= 16'd0;
            r_sram_dout_oe <= 1'b0;
            r_sram_en_n    <= 1'b1;
            r_sram_oe_n    <= 1'b1;
            r_sram_we_n    <= 1'b1;
            r_if_rdata     <= 16'd0;
            r_d_rdata      <= 16'd0;
            r_if_valid     <= 1'b0;
            r_d_valid      <= 1'b0;
        end else begin
            r_sram_en_n    <= w_en_n_nxt;
            r_sram_oe_n    <= w_oe_n_nxt;
            r_sram_we_n    <= w_we_n_nxt;
            r_sram_dout_oe <= w_dout_oe_nxt;
            r_if_valid     <= w_done_nxt & ~r_owner_d;
            r_d_valid      <= w_done_nxt & r_owner_d;
            if ((r_state == S_IDLE) && w_any_req) begin
                r_owner_d   <= w_grant_d;
                r_we        <= w_grant_d & d_we;
                r_sram_addr <= {ADDR_HI, (w_grant_d ? d_addr : if_addr)};
                if (w_grant_d & d_we) begin
                    r_sram_dout <= d_wdata;
                end
            end
            if (r_state == S_SETUP) begin
                r_cnt <= LP_CNT_INIT;
            end else if ((r_state == S_STROBE) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if ((r_state == S_STROBE) && (r_cnt == 3'd0) && !r_we) begin
                if (r_owner_d) begin
                    r_d_rdata <= sram_din;
                end else begin
                    r_if_rdata <= sram_din;
                end
            end
        end
    end

    assign sram_addr    = r_sram_addr;
    assign sram_dout    = r_sram_dout;
    assign sram_dout_oe = r_sram_dout_oe;
    assign sram_en_n    = r_sram_en_n;
    assign sram_oe_n    = r_sram_oe_n;
    assign sram_we_n    = r_sram_we_n;
    assign if_rdata     = r_if_rdata;
    assign d_rdata      = r_d_rdata;
    assign if_valid     = r_if_valid;
    assign d_valid      = r_d_valid;
    assign if_stall     = if_req & ~r_if_valid;
    assign d_stall      = d_req & ~r_d_valid;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter with a behavioural SRAM.
module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_valid;
    logic        d_stall;
    logic [17:0] sram_addr;
    logic [15:0] sram_dout;
    logic        sram_dout_oe;
    logic [15:0] sram_din;
    logic        sram_en_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    int compared;
    int mismatched;

    logic [15:0] mem [0:65535];

    logic [31:0] rec_en, rec_oe, rec_we, rec_doe, rec_iv, rec_dv, rec_is, rec_ds;
    logic [17:0] rec_addr;
    logic [7:0]  order;
    int          nval;
    int          if_more;
    int          d_more;

    ram_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_valid     (if_valid),
        .if_stall     (if_stall),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_valid      (d_valid),
        .d_stall      (d_stall),
        .sram_addr    (sram_addr),
        .sram_dout    (sram_dout),
        .sram_dout_oe (sram_dout_oe),
        .sram_din     (sram_din),
        .sram_en_n    (sram_en_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_din = (!sram_en_n && !sram_oe_n) ? mem[sram_addr[15:0]] : 16'h0000;

    always @(posedge clk) begin
        if (!sram_en_n && !sram_we_n && sram_dout_oe) mem[sram_addr[15:0]] <= sram_dout;
    end

    always @(negedge clk) begin
        if (!rst) begin
            compared++;
            assert (!(sram_dout_oe && !sram_oe_n)) else begin
                mismatched++;
                $error("FAIL bus_contention: dout_oe=%b oe_n=%b required not both active", sram_dout_oe, sram_oe_n);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Cycle 0 is the cycle during which the first request is presented.
    task automatic run(input int n);
        logic vi, vd;
        rec_en = '0; rec_oe = '0; rec_we = '0; rec_doe = '0;
        rec_iv = '0; rec_dv = '0; rec_is = '0; rec_ds = '0;
        rec_addr = '0; order = '0; nval = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rec_en[c] = sram_en_n;   rec_oe[c] = sram_oe_n;
            rec_we[c] = sram_we_n;   rec_doe[c] = sram_dout_oe;
            rec_iv[c] = if_valid;    rec_dv[c] = d_valid;
            rec_is[c] = if_stall;    rec_ds[c] = d_stall;
            if (c == 1) rec_addr = sram_addr;
            if (d_valid) begin order = {order[6:0], 1'b1}; nval++; end
            if (if_valid) begin order = {order[6:0], 1'b0}; nval++; end
            vi = if_valid;
            vd = d_valid;
            @(posedge clk); #1;
            if (vi) begin
                if (if_more > 0) begin if_more--; if_addr++; end
                else if_req = 1'b0;
            end
            if (vd) begin
                if (d_more > 0) begin d_more--; d_addr++; end
                else d_req = 1'b0;
            end
        end
    endtask

    initial begin
        compared = 0; mismatched = 0; if_more = 0; d_more = 0;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0;
        mem[16'h0040] = 16'h1234; mem[16'h0010] = 16'h5555; mem[16'h0011] = 16'h6666;
        mem[16'h0000] = 16'h1111; mem[16'h0001] = 16'h2222; mem[16'h0100] = 16'h7777;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en_n", 32'(sram_en_n), 32'h1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'h1);
        chk("rst_we_n", 32'(sram_we_n), 32'h1);
        chk("rst_dout_oe", 32'(sram_dout_oe), 32'h0);
        chk("rst_addr", 32'(sram_addr), 32'h0);
        chk("rst_valids", {30'd0, if_valid, d_valid}, 32'h0);
        chk("rst_rdata", {if_rdata, d_rdata}, 32'h0);
        rst = 1'b0;

        // Single fetch read
        if_req = 1'b1; if_addr = 16'h0040;
        run(6);
        chk("rd_en_n", rec_en[5:0], 32'b100001);
        chk("rd_oe_n", rec_oe[5:0], 32'b110011);
        chk("rd_we_n", rec_we[5:0], 32'b111111);
        chk("rd_dout_oe", rec_doe[5:0], 32'b000000);
        chk("rd_if_valid", rec_iv[5:0], 32'b010000);
        chk("rd_if_stall", rec_is[5:0], 32'b001111);
        chk("rd_addr", 32'(rec_addr), 32'h00040);
        chk("rd_if_rdata", 32'(if_rdata), 32'h1234);

        // Single data write
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h8001; d_wdata = 16'hBEEF;
        run(6);
        chk("wr_addr", 32'(rec_addr), 32'h08001);
        chk("wr_en_n", rec_en[5:0], 32'b100001);
        chk("wr_we_n", rec_we[5:0], 32'b110011);
        chk("wr_oe_n", rec_oe[5:0], 32'b111111);
        chk("wr_dout_oe", rec_doe[5:0], 32'b011110);
        chk("wr_d_valid", rec_dv[5:0], 32'b010000);
        chk("wr_d_stall", rec_ds[5:0], 32'b001111);
        chk("wr_mem", 32'(mem[16'h8001]), 32'hBEEF);

        // Simultaneous requests
        do_reset();
        d_we = 1'b0; d_addr = 16'h0010; d_req = 1'b1;
        if_addr = 16'h0040; if_req = 1'b1;
        run(11);
        chk("cf_d_valid", rec_dv[10:0], 32'b00000010000);
        chk("cf_if_valid", rec_iv[10:0], 32'b01000000000);
        chk("cf_if_stall", rec_is[10:0], 32'b00111111111);
        chk("cf_d_stall", rec_ds[10:0], 32'b00000001111);
        chk("cf_en_n", rec_en[10:0], 32'b10000100001);
        chk("cf_rdata", {if_rdata, d_rdata}, 32'h1234_5555);

        // Back-to-back fetches
        do_reset();
        if_addr = 16'h0000; if_req = 1'b1; if_more = 1;
        run(11);
        chk("b2b_if_valid", rec_iv[10:0], 32'b01000010000);
        chk("b2b_en_n", rec_en[10:0], 32'b10000100001);
        chk("b2b_if_rdata", 32'(if_rdata), 32'h2222);

        // Reset during the strobe of a write
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 16'hAAAA;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("mid_we_n_pre", 32'(sram_we_n), 32'h0);
        rst = 1'b1;
        #1;
        chk("mid_we_n", 32'(sram_we_n), 32'h1);
        chk("mid_en_n", 32'(sram_en_n), 32'h1);
        chk("mid_dout_oe", 32'(sram_dout_oe), 32'h0);
        d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        run(6);
        chk("mid_no_valid", rec_dv[5:0], 32'b000000);
        chk("mid_idle_en_n", rec_en[5:0], 32'b111111);
        chk("mid_mem", 32'(mem[16'h0100]), 32'h7777);
        d_we = 1'b0; d_addr = 16'h0010; d_req = 1'b1;
        run(6);
        chk("post_d_valid", rec_dv[5:0], 32'b010000);
        chk("post_d_rdata", 32'(d_rdata), 32'h5555);

        // Continuous contention: arbitration order
        do_reset();
        d_we = 1'b0; d_addr = 16'h0010; d_req = 1'b1; d_more = 1;
        if_addr = 16'h0000; if_req = 1'b1; if_more = 1;
        run(21);
        chk("arb_count", 32'(nval), 32'd4);
`ifdef ARB_RR_EN
        chk("arb_order", 32'(order[3:0]), 32'b1010);
`else
        chk("arb_order", 32'(order[3:0]), 32'b1100);
`endif
        chk("arb_rdata", {if_rdata, d_rdata}, 32'h2222_6666);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
